tournament_branch_predictor: RTL and testbench
==============================================

Name: tournament_branch_predictor

Overview:
- Direction predictor feeding the stall/control unit.
- IF stage: reads a local (per-PC history) predictor, a gshare global predictor and a tournament chooser, and produces `if_br_pr`.
- Carries local/global/final predictions and table indices alongside the IF/ID register so the ID stage sees `id_local_pr`, `id_global_pr` and `id_br_pr`.
- Applies the ghr/bht/pht/tournament update strobes from the control unit at the captured ID indices.

Parameters:
- `IDX_W`, 8: PC bits [IDX_W+1:2] index the BHT and the chooser; 2^IDX_W entries each.
- `HIST_W`, 8: width of the GHR and of each BHT entry; both PHTs have 2^HIST_W entries.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_pc`  in  32  PC currently being fetched.
- `if_id_load`  in  1  IF/ID register load (same signal driving the pipeline register).
- `if_id_flush`  in  1  IF/ID register flush.
- `id_br_en`  in  1  resolved branch outcome of the instruction in ID.
- `ghr_load`  in  1  shift `id_br_en` into the GHR.
- `bht_load`  in  1  shift `id_br_en` into the BHT entry at the captured ID index.
- `increment_pht`, `decrement_pht`  in  1 each  update both PHT entries at the captured ID indices.
- `increment_tournament_pht`, `decrement_tournament_pht`  in  1 each  update the chooser entry at the captured ID index.
- `if_br_pr`  out  1  combinational final prediction for `if_pc`.
- `id_local_pr`, `id_global_pr`, `id_br_pr`  out  1 each  registered predictions for the instruction in ID.

Behaviour:
- State:
  - GHR[HIST_W].
  - BHT[2^IDX_W][HIST_W].
  - LPHT[2^HIST_W][2].
  - GPHT[2^HIST_W][2].
  - CHOOSE[2^IDX_W][2].
  - ID capture register: `id_local_pr`, `id_global_pr`, `id_br_pr`, `id_pc_idx`, `id_lhist`, `id_gidx`.
  - All state is flops, so async reset is possible.
- Reset (`rst`=0, asynchronous):
  - GHR=0 and all BHT entries=0.
  - LPHT/GPHT entries=2'b01 (weakly not-taken).
  - CHOOSE entries=2'b01 (weakly local).
  - Capture register=0, so all `id_*` outputs are 0.
  - Reset mid-operation discards all training.
- IF read (combinational, zero latency):
  - `pc_idx` = `if_pc`[IDX_W+1:2].
  - `lhist` = BHT[pc_idx].
  - `gidx` = GHR XOR `if_pc`[HIST_W+1:2].
  - `local_pr` = LPHT[lhist][1].
  - `global_pr` = GPHT[gidx][1].
  - `if_br_pr` = (CHOOSE[pc_idx] >= 2) ? `global_pr` : `local_pr`.
  - Reads return pre-edge state; there is no same-cycle forwarding from updates.
- Capture (rising edge), in priority order:
  - `if_id_flush`=1 (with or without `if_id_load`): clear the capture register to 0.
  - else `if_id_load`=1: load `local_pr`, `global_pr`, `if_br_pr`, `pc_idx`, `lhist`, `gidx`.
  - else: hold.
  - Capture and update use the same edge. Updates use the old capture contents.
- Updates (rising edge, independent of capture):
  - `ghr_load`: GHR <= {GHR[HIST_W-2:0], `id_br_en`}.
  - `bht_load`: BHT[`id_pc_idx`] <= {BHT[`id_pc_idx`][HIST_W-2:0], `id_br_en`}.
  - `increment_pht`: LPHT[`id_lhist`] and GPHT[`id_gidx`] each saturate-increment; 2'b11 stays 2'b11.
  - `decrement_pht`: both saturate-decrement; 2'b00 stays 2'b00.
  - `increment_tournament_pht`: CHOOSE[`id_pc_idx`] saturate-increment (toward global).
  - `decrement_tournament_pht`: CHOOSE[`id_pc_idx`] saturate-decrement (toward local).
  - Increment and decrement of the same table asserted together: that table is unchanged.
- Snapshot indices:
  - The PHT update uses the captured `id_lhist`/`id_gidx`, not the live BHT/GHR. Training always hits the entry that produced the prediction, even if GHR/BHT changed between IF and ID.
- Stalls:
  - During a stall (`if_id_load`=0, no flush) the `id_*` outputs hold.
  - The control unit gates its strobes while stalled, so tables are not double-updated. This block applies strobes unconditionally whenever they are asserted.
- Arithmetic:
  - All counters are 2-bit unsigned. Index math wraps modulo table size.
  - PC bits [1:0] are ignored.

Test Plan:
- Reset:
  - Stimulus: assert `rst`=0 mid-run, release, read any `if_pc`.
  - Required: `if_br_pr`=0 and all `id_*`=0 immediately.
  - Required: after one capture with `if_id_load`=1, `id_local_pr`=`id_global_pr`=`id_br_pr`=0.
- Saturation:
  - Stimulus: capture `if_pc`=0x40, then pulse `increment_pht` 4 times with capture held (`if_id_load`=0).
  - Required: the LPHT/GPHT entries read 2'b11 and `if_br_pr` for 0x40 becomes 1 after the first pulse.
  - Stimulus: 4 `decrement_pht` pulses.
  - Required: entries read 2'b00, `if_br_pr`=0.
- Chooser:
  - Stimulus: train so LPHT predicts 0 and GPHT predicts 1 for 0x80; pulse `increment_tournament_pht` once from reset.
  - Required: CHOOSE=2, `if_br_pr` switches from 0 to 1.
  - Stimulus: one `decrement_tournament_pht` pulse.
  - Required: `if_br_pr` returns to 0.
- History:
  - Stimulus: `id_br_en`=1 with `ghr_load`=`bht_load`=1 for 3 edges.
  - Required: GHR=0x07 and BHT[captured idx]=0x07.
  - Required: `gidx` for `if_pc`=0x1C equals 0x07^0x07=0x00.
- Flush vs load:
  - Stimulus: `if_id_flush`=1 and `if_id_load`=1 while IF predicts 1.
  - Required: all `id_*`=0 next cycle.
  - Stimulus: `if_id_load`=0, `if_id_flush`=0.
  - Required: previous `id_*` values held for every stalled cycle.
- Same-edge update/read:
  - Stimulus: ID update of LPHT entry E 01->10 on the same edge that IF reads entry E.
  - Required: the captured `id_local_pr`=0 (old value); the next IF read of E gives 1.

Source files
------------

// File: rtl/tournament_branch_predictor_if.sv
// Fetch/decode-side signals of the tournament branch predictor: IF lookup,
// IF/ID capture control, ID-stage training strobes and the predictions.
interface tournament_branch_predictor_if;
  logic [31:0] if_pc;
  logic        if_id_load;
  logic        if_id_flush;
  logic        id_br_en;
  logic        ghr_load;
  logic        bht_load;
  logic        increment_pht;
  logic        decrement_pht;
  logic        increment_tournament_pht;
  logic        decrement_tournament_pht;
  logic        if_br_pr;
  logic        id_local_pr;
  logic        id_global_pr;
  logic        id_br_pr;

  modport master (
    output if_pc, if_id_load, if_id_flush, id_br_en, ghr_load, bht_load,
           increment_pht, decrement_pht,
           increment_tournament_pht, decrement_tournament_pht,
    input  if_br_pr, id_local_pr, id_global_pr, id_br_pr
  );

  modport slave (
    input  if_pc, if_id_load, if_id_flush, id_br_en, ghr_load, bht_load,
           increment_pht, decrement_pht,
           increment_tournament_pht, decrement_tournament_pht,
    output if_br_pr, id_local_pr, id_global_pr, id_br_pr
  );
endinterface

// File: rtl/tournament_branch_predictor.sv
// Tournament direction predictor: per-PC local history, gshare global and a
// chooser; predictions and table indices ride along with the IF/ID register.
module tournament_branch_predictor #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned HIST_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  tournament_branch_predictor_if.slave bp
);

  localparam int unsigned PC_N = 1 << IDX_W;
  localparam int unsigned H_N  = 1 << HIST_W;

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [HIST_W-1:0] bht_q    [PC_N];
  logic [1:0]        lpht_q   [H_N];
  logic [1:0]        gpht_q   [H_N];
  logic [1:0]        choose_q [PC_N];

  logic              id_local_pr_q, id_local_pr_d;
  logic              id_global_pr_q, id_global_pr_d;
  logic              id_br_pr_q, id_br_pr_d;
  logic [IDX_W-1:0]  id_pc_idx_q, id_pc_idx_d;
  logic [HIST_W-1:0] id_lhist_q, id_lhist_d;
  logic [HIST_W-1:0] id_gidx_q, id_gidx_d;

  logic [IDX_W-1:0]  pc_idx_c;
  logic [HIST_W-1:0] lhist_c, gidx_c;
  logic              local_pr_c, global_pr_c, br_pr_c;
  logic [HIST_W-1:0] bht_d;
  logic [1:0]        lpht_d, gpht_d, choose_d;
  logic              pht_upd_c, choose_upd_c;
  logic              unused_pc_bits;

  // Saturating 2-bit counter; simultaneous inc and dec leave it unchanged.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt,
                                          input logic inc, input logic dec);
    logic [1:0] res;
    res = cnt;
    if (inc && !dec && cnt != 2'b11) res = cnt + 2'd1;
    if (dec && !inc && cnt != 2'b00) res = cnt - 2'd1;
    return res;
  endfunction

  assign unused_pc_bits = ^bp.if_pc;

  always_comb begin
    pc_idx_c    = bp.if_pc[IDX_W+1:2];
    lhist_c     = bht_q[pc_idx_c];
    gidx_c      = ghr_q ^ bp.if_pc[HIST_W+1:2];
    local_pr_c  = lpht_q[lhist_c][1];
    global_pr_c = gpht_q[gidx_c][1];
    br_pr_c     = choose_q[pc_idx_c][1] ? global_pr_c : local_pr_c;
  end

  assign bp.if_br_pr     = br_pr_c;
  assign bp.id_local_pr  = id_local_pr_q;
  assign bp.id_global_pr = id_global_pr_q;
  assign bp.id_br_pr     = id_br_pr_q;

  // Training always targets the indices captured with the prediction.
  always_comb begin
    ghr_d        = ghr_q;
    bht_d        = bht_q[id_pc_idx_q];
    pht_upd_c    = bp.increment_pht ^ bp.decrement_pht;
    choose_upd_c = bp.increment_tournament_pht ^ bp.decrement_tournament_pht;
    if (bp.ghr_load) ghr_d = {ghr_q[HIST_W-2:0], bp.id_br_en};
    if (bp.bht_load) bht_d = {bht_q[id_pc_idx_q][HIST_W-2:0], bp.id_br_en};
    lpht_d   = sat_step(lpht_q[id_lhist_q], bp.increment_pht, bp.decrement_pht);
    gpht_d   = sat_step(gpht_q[id_gidx_q], bp.increment_pht, bp.decrement_pht);
    choose_d = sat_step(choose_q[id_pc_idx_q], bp.increment_tournament_pht,
                        bp.decrement_tournament_pht);
  end

  // Flush wins over load; otherwise the capture register holds.
  always_comb begin
    id_local_pr_d  = id_local_pr_q;
    id_global_pr_d = id_global_pr_q;
    id_br_pr_d     = id_br_pr_q;
    id_pc_idx_d    = id_pc_idx_q;
    id_lhist_d     = id_lhist_q;
    id_gidx_d      = id_gidx_q;
    if (bp.if_id_flush) begin
      id_local_pr_d  = 1'b0;
      id_global_pr_d = 1'b0;
      id_br_pr_d     = 1'b0;
      id_pc_idx_d    = '0;
      id_lhist_d     = '0;
      id_gidx_d      = '0;
    end else if (bp.if_id_load) begin
      id_local_pr_d  = local_pr_c;
      id_global_pr_d = global_pr_c;
      id_br_pr_d     = br_pr_c;
      id_pc_idx_d    = pc_idx_c;
      id_lhist_d     = lhist_c;
      id_gidx_d      = gidx_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q          <= '0;
      id_local_pr_q  <= 1'b0;
      id_global_pr_q <= 1'b0;
      id_br_pr_q     <= 1'b0;
      id_pc_idx_q    <= '0;
      id_lhist_q     <= '0;
      id_gidx_q      <= '0;
      for (int unsigned i = 0; i < PC_N; i++) begin
        bht_q[IDX_W'(i)]    <= '0;
        choose_q[IDX_W'(i)] <= 2'b01;
      end
      for (int unsigned i = 0; i < H_N; i++) begin
        lpht_q[HIST_W'(i)] <= 2'b01;
        gpht_q[HIST_W'(i)] <= 2'b01;
      end
    end else begin
      ghr_q          <= ghr_d;
      id_local_pr_q  <= id_local_pr_d;
      id_global_pr_q <= id_global_pr_d;
      id_br_pr_q     <= id_br_pr_d;
      id_pc_idx_q    <= id_pc_idx_d;
      id_lhist_q     <= id_lhist_d;
      id_gidx_q      <= id_gidx_d;
      if (bp.bht_load) bht_q[id_pc_idx_q] <= bht_d;
      if (pht_upd_c) begin
        lpht_q[id_lhist_q] <= lpht_d;
        gpht_q[id_gidx_q]  <= gpht_d;
      end
      if (choose_upd_c) choose_q[id_pc_idx_q] <= choose_d;
    end
  end

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Directed self-checking bench for tournament_branch_predictor with
// hand-computed predictions for each training step.
module tb_tournament_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  tournament_branch_predictor_if bp();

  tournament_branch_predictor #(.IDX_W(8), .HIST_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] pc);
    bp.if_pc      = pc;
    bp.if_id_load = 1'b1;
    step();
    bp.if_id_load = 1'b0;
  endtask

  task automatic pulse_pht(input logic inc, input int n);
    for (int k = 0; k < n; k++) begin
      bp.increment_pht = inc;
      bp.decrement_pht = ~inc;
      step();
      bp.increment_pht = 1'b0;
      bp.decrement_pht = 1'b0;
    end
  endtask

  task automatic pulse_choose(input logic inc);
    bp.increment_tournament_pht = inc;
    bp.decrement_tournament_pht = ~inc;
    step();
    bp.increment_tournament_pht = 1'b0;
    bp.decrement_tournament_pht = 1'b0;
  endtask

  task automatic pred_chk(input string tag, input logic [31:0] pc, input logic exp);
    bp.if_pc = pc;
    #1;
    check(tag, 32'(bp.if_br_pr), 32'(exp));
  endtask

  task automatic id_chk(input string tag, input logic [2:0] exp);
    check(tag, 32'({bp.id_local_pr, bp.id_global_pr, bp.id_br_pr}), 32'(exp));
  endtask

  initial begin
    bp.if_pc = 32'h0;
    bp.if_id_load = 1'b0;
    bp.if_id_flush = 1'b0;
    bp.id_br_en = 1'b0;
    bp.ghr_load = 1'b0;
    bp.bht_load = 1'b0;
    bp.increment_pht = 1'b0;
    bp.decrement_pht = 1'b0;
    bp.increment_tournament_pht = 1'b0;
    bp.decrement_tournament_pht = 1'b0;
    #2 rst = 1'b0;
    #1;
    pred_chk("reset_pred", 32'h40, 1'b0);
    id_chk("reset_id", 3'b000);
    step();
    step();
    rst = 1'b1;
    step();

    // Saturation on LPHT[0] / GPHT[0x10]
    pred_chk("sat_pre", 32'h40, 1'b0);
    capture(32'h40);
    id_chk("sat_cap", 3'b000);
    pulse_pht(1'b1, 1);
    pred_chk("sat_inc1", 32'h40, 1'b1);
    pulse_pht(1'b1, 3);
    pred_chk("sat_inc4", 32'h40, 1'b1);
    id_chk("sat_id_hold", 3'b000);
    pulse_pht(1'b0, 1);
    pred_chk("sat_dec1", 32'h40, 1'b1);
    pulse_pht(1'b0, 1);
    pred_chk("sat_dec2", 32'h40, 1'b0);
    pulse_pht(1'b0, 2);
    pred_chk("sat_dec4", 32'h40, 1'b0);
    pulse_pht(1'b1, 1);
    pred_chk("sat_floor", 32'h40, 1'b0);

    // Chooser: LPHT[0]=00, GPHT[0x20]=10 for pc 0x80
    capture(32'h80);
    pulse_pht(1'b1, 1);
    capture(32'h84);
    pulse_pht(1'b0, 2);
    pred_chk("ch_local", 32'h80, 1'b0);
    capture(32'h80);
    id_chk("ch_cap", 3'b010);
    pulse_choose(1'b1);
    pred_chk("ch_global", 32'h80, 1'b1);
    pulse_choose(1'b0);
    pred_chk("ch_back", 32'h80, 1'b0);

    // History: GHR=7, BHT[7]=7
    capture(32'h1C);
    bp.id_br_en = 1'b1;
    bp.ghr_load = 1'b1;
    bp.bht_load = 1'b1;
    repeat (3) step();
    bp.id_br_en = 1'b0;
    bp.ghr_load = 1'b0;
    bp.bht_load = 1'b0;
    capture(32'h1C);
    id_chk("hist_cap", 3'b000);
    pulse_pht(1'b1, 1);
    pred_chk("hist_lhist", 32'h1C, 1'b1);
    pulse_choose(1'b1);
    pred_chk("hist_gidx", 32'h1C, 1'b1);
    pred_chk("hist_other", 32'h00, 1'b0);

    // Flush beats load; stall holds
    capture(32'h1C);
    id_chk("fl_load", 3'b111);
    bp.if_id_flush = 1'b1;
    bp.if_id_load  = 1'b1;
    step();
    bp.if_id_flush = 1'b0;
    bp.if_id_load  = 1'b0;
    id_chk("fl_flush", 3'b000);
    capture(32'h1C);
    id_chk("fl_reload", 3'b111);
    bp.if_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      step();
      id_chk($sformatf("fl_stall%0d", k), 3'b111);
    end

    // Same-edge update and read of LPHT[0]
    capture(32'h80);
    pulse_pht(1'b1, 1);
    pred_chk("se_pre", 32'h84, 1'b0);
    bp.increment_pht = 1'b1;
    bp.if_id_load    = 1'b1;
    step();
    bp.increment_pht = 1'b0;
    bp.if_id_load    = 1'b0;
    id_chk("se_cap_old", 3'b000);
    pred_chk("se_new", 32'h84, 1'b1);

    // Reset mid-run discards training
    pred_chk("rr_pre", 32'h1C, 1'b1);
    capture(32'h1C);
    id_chk("rr_cap", 3'b111);
    rst = 1'b0;
    #1;
    pred_chk("rr_pred", 32'h1C, 1'b0);
    id_chk("rr_id", 3'b000);
    step();
    step();
    rst = 1'b1;
    capture(32'h1C);
    id_chk("rr_cap_after", 3'b000);
    pred_chk("rr_pred_after", 32'h1C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
